// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Transmit byte FIFO between the APB register block and the
//                I2C master. Rising edge of write_enable pushes a byte,
//                read_enable pops one into a registered data_out. Provides
//                full/empty, threshold flags, occupancy and sticky
//                overflow/underflow flags. Two synchronous flush inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int ADDRWIDTH = 4,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 write_reset_n,
    input  logic                 read_reset_n,
    input  logic                 write_enable,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic                 read_enable,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic [ADDRWIDTH:0]   level
);

    localparam logic [ADDRWIDTH:0] c_DEPTH   = DEPTH[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] c_AF      = AF_LEVEL[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] c_AE      = AE_LEVEL[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] c_PTR_ONE = {{ADDRWIDTH{1'b0}}, 1'b1};

    logic [DATAWIDTH-1:0] r_mem [DEPTH];
    logic [ADDRWIDTH:0]   r_wr_ptr;
    logic [ADDRWIDTH:0]   r_rd_ptr;
    logic                 r_we_d;

    logic                 w_push;
    logic                 w_flush;
    logic                 w_is_empty;
    logic                 w_is_full;
    logic                 w_do_push;
    logic                 w_do_pop;
    logic                 w_ovf_set;
    logic                 w_unf_set;
    logic [ADDRWIDTH:0]   w_wr_ptr_nxt;
    logic [ADDRWIDTH:0]   w_rd_ptr_nxt;
    logic [ADDRWIDTH:0]   w_level_nxt;

    // Push is the rising edge of write_enable; either flush input empties the FIFO.
    // At full a simultaneous pop frees the slot the push lands in.
    always_comb begin
        w_push       = write_enable & ~r_we_d;
        w_flush      = ~write_reset_n | ~read_reset_n;
        w_is_empty   = (r_wr_ptr == r_rd_ptr);
        w_is_full    = (r_wr_ptr[ADDRWIDTH] != r_rd_ptr[ADDRWIDTH]) &&
                       (r_wr_ptr[ADDRWIDTH-1:0] == r_rd_ptr[ADDRWIDTH-1:0]);
        w_do_pop     = read_enable & ~w_flush & ~w_is_empty;
        w_do_push    = w_push & ~w_flush & (~w_is_full | w_do_pop);
        w_ovf_set    = w_push & ~w_flush & w_is_full & ~read_enable;
        w_unf_set    = read_enable & ~w_flush & w_is_empty;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_do_push) w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
        end
        w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    // Storage array; contents survive flushes and reset, only pointers move.
    always_ff @(posedge PCLK) begin
        if (w_do_push) r_mem[r_wr_ptr[ADDRWIDTH-1:0]] <= data_in;
    end

    // Pointers, edge-detect history, popped byte and all status flags,
    // registered from the post-edge occupancy so outputs never see inputs directly.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_we_d       <= 1'b0;
            data_out     <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_we_d       <= write_enable;
            level        <= w_level_nxt;
            full         <= (w_level_nxt == c_DEPTH);
            empty        <= (w_level_nxt == '0);
            almost_full  <= (w_level_nxt >= c_AF);
            almost_empty <= (w_level_nxt <= c_AE);

            if (!read_reset_n)  data_out <= '0;
            else if (w_do_pop)  data_out <= r_mem[r_rd_ptr[ADDRWIDTH-1:0]];

            if (!write_reset_n) overflow <= 1'b0;
            else if (w_ovf_set) overflow <= 1'b1;

            if (!read_reset_n)  underflow <= 1'b0;
            else if (w_unf_set) underflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire
